// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared core constants and instruction-memory controller state type
// Contents: XLEN, NOP_INSTR (addi x0,x0,0), imem_state_t (IDLE/LOAD/RUN).
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - loader stream, fetch port and status bundle for imem_load_ctrl
// Loader: reload, ld_valid/ld_ready/ld_data/ld_last.
// Fetch : fetch_en/fetch_pc -> instr/instr_valid/fetch_fault.
// Status: cpu_stall, loaded, ld_overflow, word_count.
// master = loader + IF stage side, slave = controller side.
interface imem_load_ctrl_if
    import rv_pkg::*;
#(
    parameter int AW = 8
);
    logic            reload;
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_data;
    logic            ld_last;
    logic            fetch_en;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            fetch_fault;
    logic            cpu_stall;
    logic            loaded;
    logic            ld_overflow;
    logic [AW:0]     word_count;

    modport master (
        output reload, ld_valid, ld_data, ld_last, fetch_en, fetch_pc,
        input  ld_ready, instr, instr_valid, fetch_fault, cpu_stall,
               loaded, ld_overflow, word_count
    );

    modport slave (
        input  reload, ld_valid, ld_data, ld_last, fetch_en, fetch_pc,
        output ld_ready, instr, instr_valid, fetch_fault, cpu_stall,
               loaded, ld_overflow, word_count
    );

endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single-port synchronous instruction RAM, 1-cycle read latency
// Ports: clk; en (access this cycle); we (write when en, else read);
//        addr (word address); wdata; rdata (valid the cycle after a read).
// The array and read register are not reset so the RAM maps onto block memory.
module imem_ram
    import rv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - shares the instruction RAM between the program loader and IF stage
// Ports: clk, reset (synchronous, active-high); bus (imem_load_ctrl_if.slave):
//   loader stream writes consecutive words while IDLE/LOAD with the core stalled,
//   then in RUN the IF stage gets one instruction per cycle with 1-cycle latency.
//   reload returns to IDLE at any time; RAM contents survive reload and reset.
module imem_load_ctrl
    import rv_pkg::*;
#(
    parameter int              DEPTH = 256,
    parameter int              AW    = 8,
    parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    imem_load_ctrl_if.slave   bus
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    imem_state_t     state_q, state_d;
    logic [AW:0]     word_count_q, word_count_d;
    logic            loaded_q, loaded_d;
    logic            ld_overflow_q, ld_overflow_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fetch_fault_q, fetch_fault_d;

    logic            in_load;
    logic            ld_fire;
    logic            full;
    logic            fetch_req;
    logic            pc_bad;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_rdata;

    assign in_load = (state_q == IDLE) || (state_q == LOAD);

    // ld_ready and cpu_stall are pure state decodes; reload overrides a
    // same-cycle handshake below so the word is simply dropped.
    assign bus.ld_ready  = in_load;
    assign bus.cpu_stall = (state_q != RUN);

    assign ld_fire   = bus.ld_valid && in_load && !bus.reload;
    assign full      = (word_count_q == FULL_COUNT);
    assign fetch_req = (state_q == RUN) && bus.fetch_en && !bus.reload;

    // Out-of-range addresses are treated like misaligned ones: no RAM access,
    // faulted NOP returned.
    assign pc_bad = (bus.fetch_pc[1:0] != 2'b00) || (bus.fetch_pc[XLEN-1:AW+2] != '0);

    // Once the array is full the loader keeps draining but nothing is written,
    // so addresses never wrap onto the start of the program.
    assign ram_we   = ld_fire && !full;
    assign ram_en   = ram_we || (fetch_req && !pc_bad);
    assign ram_addr = in_load ? word_count_q[AW-1:0] : bus.fetch_pc[AW+1:2];

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.ld_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        word_count_d  = word_count_q;
        loaded_d      = loaded_q;
        ld_overflow_d = ld_overflow_q;
        instr_valid_d = fetch_req;
        fetch_fault_d = fetch_req && pc_bad;

        if (bus.reload) begin
            state_d       = IDLE;
            word_count_d  = '0;
            loaded_d      = 1'b0;
            ld_overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (ld_fire) begin
                        if (full) begin
                            ld_overflow_d = 1'b1;
                        end else begin
                            word_count_d = word_count_q + 1'b1;
                        end
                        if (bus.ld_last) begin
                            state_d  = RUN;
                            loaded_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            word_count_q  <= '0;
            loaded_q      <= 1'b0;
            ld_overflow_q <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_count_q  <= word_count_d;
            loaded_q      <= loaded_d;
            ld_overflow_q <= ld_overflow_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // The RAM read register carries stale data after writes or idle cycles,
    // so instr is gated by the registered valid/fault flags.
    assign bus.instr       = (instr_valid_q && !fetch_fault_q) ? ram_rdata : NOP;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.loaded      = loaded_q;
    assign bus.ld_overflow = ld_overflow_q;
    assign bus.word_count  = word_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;
    import rv_pkg::*;

    localparam int TB_DEPTH = 256;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    imem_load_ctrl_if #(.AW(8)) bus ();

    imem_load_ctrl #(
        .DEPTH (TB_DEPTH),
        .AW    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [TB_DEPTH];
    int          mdl_count;
    bit          mdl_loaded;
    bit          mdl_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bad_pc(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= TB_DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        if (bad_pc(pc)) return NOP_INSTR;
        return mdl_mem[pc / 4];
    endfunction

    task automatic model_clear();
        mdl_count  = 0;
        mdl_loaded = 0;
        mdl_ovf    = 0;
    endtask

    task automatic check_status(input string tag, input bit stall);
        check({tag, ".word_count"},  64'(bus.word_count), 64'(mdl_count));
        check({tag, ".loaded"},      64'(bus.loaded), 64'(mdl_loaded));
        check({tag, ".ld_overflow"}, 64'(bus.ld_overflow), 64'(mdl_ovf));
        check({tag, ".cpu_stall"},   64'(bus.cpu_stall), 64'(stall));
        check({tag, ".ld_ready"},    64'(bus.ld_ready), 64'(stall));
    endtask

    task automatic check_idle_fetch(input string tag);
        check({tag, ".instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, ".instr"},       64'(bus.instr), 64'(NOP_INSTR));
        check({tag, ".fetch_fault"}, 64'(bus.fetch_fault), 64'd0);
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        check("ld_ready_before_word", 64'(bus.ld_ready), 64'd1);
        step();
        if (mdl_count < TB_DEPTH) begin
            mdl_mem[mdl_count] = d;
            mdl_count++;
        end else begin
            mdl_ovf = 1;
        end
        if (last) mdl_loaded = 1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] pc);
        bus.fetch_en = 1'b1;
        bus.fetch_pc = pc;
        step();
        check($sformatf("fetch_valid@%0h", pc), 64'(bus.instr_valid), 64'd1);
        check($sformatf("fetch_instr@%0h", pc), 64'(bus.instr), 64'(exp_instr(pc)));
        check($sformatf("fetch_fault@%0h", pc), 64'(bus.fetch_fault), 64'(bad_pc(pc)));
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [31:0] pc;
        bit          en;
        total = 0;
        bad   = 0;
        prog[0] = 32'h0050_0113;
        prog[1] = 32'h00C0_0193;
        prog[2] = 32'hFF71_8393;
        prog[3] = 32'h0023_E233;

        reset        = 1'b1;
        bus.reload   = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.fetch_en = 1'b0;
        bus.fetch_pc = '0;
        model_clear();
        step();
        step();
        check_status("reset", 1'b1);
        check_idle_fetch("reset");
        reset = 1'b0;
        step();
        check_status("post_reset", 1'b1);

        // Directed 4-word program, fetch served the cycle after the last word
        for (int i = 0; i < 4; i++) send_word(prog[i], i == 3);
        check_status("load4", 1'b0);
        check("load4.wc_is_4", 64'(bus.word_count), 64'd4);
        fetch_one(32'h8);
        check("load4.instr_lit", 64'(bus.instr), 64'hFF71_8393);

        // Back-to-back fetches then an idle cycle
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'hC);
        bus.fetch_en = 1'b0;
        step();
        check_idle_fetch("b2b_gap");

        fetch_one(32'h6);
        fetch_one(32'h400);
        fetch_one(32'h0);
        bus.fetch_en = 1'b0;

        // Loader words outside IDLE/LOAD are ignored
        bus.ld_valid = 1'b1;
        bus.ld_data  = $urandom;
        bus.ld_last  = 1'b1;
        check("run.ld_ready", 64'(bus.ld_ready), 64'd0);
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check_status("run_ignore", 1'b0);

        // reload with a same-cycle fetch discards the fetch
        bus.reload   = 1'b1;
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h4;
        step();
        bus.reload   = 1'b0;
        bus.fetch_en = 1'b0;
        model_clear();
        check_idle_fetch("reload_fetch");
        check_status("reload_fetch", 1'b1);
        send_word($urandom, 1'b0);
        check_status("reload_mid", 1'b1);
        send_word($urandom, 1'b1);
        check_status("reload_done", 1'b0);
        for (int a = 0; a < 16; a += 4) fetch_one(32'(a));
        bus.fetch_en = 1'b0;

        // Overflow: 257 words without last, then a 258th with last
        pulse_reload();
        check_status("ovf_start", 1'b1);
        for (int i = 0; i < 257; i++) begin
            send_word($urandom, 1'b0);
            if (i == 255) check_status("ovf_at_depth", 1'b1);
        end
        check_status("ovf_257", 1'b1);
        send_word($urandom, 1'b1);
        check_status("ovf_done", 1'b0);
        check("ovf.wc_256", 64'(bus.word_count), 64'd256);
        fetch_one(32'h0);
        fetch_one(32'h3FC);

        // Randomized fetch traffic with gaps, faults and out-of-range PCs
        for (int i = 0; i < 60; i++) begin
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1:    pc = 32'($urandom_range(0, TB_DEPTH - 1)) * 4;
                2:       pc = ($urandom & 32'h3FF) | 32'($urandom_range(1, 3));
                default: pc = $urandom | 32'h0000_0400;
            endcase
            bus.fetch_en = en;
            bus.fetch_pc = pc;
            step();
            check("rnd.valid", 64'(bus.instr_valid), 64'(en));
            check("rnd.instr", 64'(bus.instr), en ? 64'(exp_instr(pc)) : 64'(NOP_INSTR));
            check("rnd.fault", 64'(bus.fetch_fault), 64'(en && bad_pc(pc)));
        end
        bus.fetch_en = 1'b0;

        // Reset after 2 of 5 words, then a full 5-word load
        pulse_reload();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        check_status("partial", 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        check_status("midload_reset", 1'b1);
        check_idle_fetch("midload_reset");
        for (int i = 0; i < 5; i++) send_word($urandom, i == 4);
        check_status("reload5", 1'b0);
        for (int a = 0; a < 28; a += 4) fetch_one(32'(a));
        bus.fetch_en = 1'b0;
        step();
        check_idle_fetch("final_gap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that owns the single-port instruction RAM of the pipelined RISC-V core and shares it between a streaming program loader (write side) and the IF stage (read side). After reset it holds the pipeline stalled while the loader streams words into consecutive addresses. It then hands the RAM to fetch, returning one instruction per cycle with 1-cycle latency. It replaces file-based preload, so programs can be (re)loaded at run time.

## Interface
- DEPTH, 256, instruction RAM depth in 32-bit words (power of two)
- AW, 8, word-address width, log2(DEPTH)
- NOP, 32'h00000013, instruction returned when no valid fetch data exists (addi x0,x0,0)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- reload  in  1  pulse; restart program loading from word 0
- ld_valid  in  1  loader word valid
- ld_ready  out  1  controller accepts loader word
- ld_data  in  32  instruction word to write
- ld_last  in  1  qualifies final word of a program
- fetch_en  in  1  IF stage requests a fetch this cycle
- fetch_pc  in  32  byte address of requested instruction
- instr  out  32  fetched instruction (NOP when invalid)
- instr_valid  out  1  instr corresponds to the fetch accepted last cycle
- fetch_fault  out  1  with instr_valid: last fetch misaligned or out of range
- cpu_stall  out  1  holds PC/IF-ID registers while not in RUN
- loaded  out  1  a complete program is present
- ld_overflow  out  1  sticky: loader supplied more than DEPTH words
- word_count  out  AW+1  words written by the current/last load

## Operation
- FSM states: IDLE, LOAD, RUN.
- IDLE: entered on reset. ld_ready=1, cpu_stall=1. The first accepted word moves the FSM to LOAD, or directly to RUN if ld_last=1.
- LOAD: each ld_valid&ld_ready handshake writes ld_data at address word_count[AW-1:0], then increments word_count. The handshake carrying ld_last moves the FSM to RUN on the next cycle. loaded is set on that edge.
- Overflow: when word_count==DEPTH, further words are accepted (ld_ready stays 1 so the loader drains) but not written. ld_overflow is set and word_count saturates at DEPTH.
- RUN: ld_ready=0 and cpu_stall=0. fetch_en reads RAM word fetch_pc[AW+1:2].
  - fetch_pc[1:0]!=0: RAM is not read; the next cycle gives instr=NOP, fetch_fault=1, instr_valid=1.
  - fetch_pc[31:AW+2]!=0: handled the same way as a misaligned PC.
- reload (any state): next state IDLE. word_count, loaded and ld_overflow clear, and cpu_stall asserts. A fetch issued in the same cycle is discarded (instr_valid=0 next cycle). RAM contents are not cleared.
- ld_valid outside IDLE/LOAD is ignored.

## Timing
- Reset values: state=IDLE, ld_ready=1, cpu_stall=1, instr=NOP, instr_valid=0, fetch_fault=0, loaded=0, ld_overflow=0, word_count=0.
- Loader throughput: one word per cycle, with no bubbles.
- Last-word handshake in cycle N: loaded=1 and cpu_stall=0 from cycle N+1. A fetch_en in cycle N+1 is served.
- Fetch latency: 1 cycle. A request in cycle N produces instr and instr_valid in cycle N+1. Back-to-back requests are fully pipelined.
- instr holds NOP and instr_valid=0 in any cycle following no accepted fetch.
- Reset mid-load behaves exactly like reload. A partially written program stays in RAM, but loaded=0.
- Outputs are registered, except ld_ready and cpu_stall, which decode state only.

## Structure
- Shared package rv_pkg holds:
  - NOP_INSTR constant
  - imem_state_t enum (IDLE/LOAD/RUN)
  - XLEN=32
- Sub-module imem_ram: single-port synchronous RAM with one write or read per cycle, 1-cycle read latency, no reset on the array. The controller muxes the RAM address between word_count and fetch_pc.

## Test plan
- Reset, then stream 4 words 0x00500113, 0x00C00193, 0xFF718393, 0x0023E233 with ld_last on word 4.
  - Expect loaded=1 and cpu_stall=0 the cycle after, with word_count=4.
  - fetch_pc=0x8 then returns 0xFF718393, instr_valid=1, one cycle later.
- Back-to-back fetches of pc 0x0, 0x4, 0xC return the three words on consecutive cycles, with no gaps.
- fetch_pc=0x6 gives instr=0x00000013 and fetch_fault=1. fetch_pc=0x400 (DEPTH=256) gives the same NOP/fault response.
- Stream 257 words without ld_last, then a 258th word with ld_last.
  - Expect ld_overflow=1 and word_count=256.
  - Word 0 is unchanged, and the FSM reaches RUN.
- Assert reload together with fetch_en while in RUN.
  - Expect instr_valid=0 next cycle and cpu_stall=1, with loaded=0 and word_count=0.
  - A new load of 2 words then overwrites addresses 0 and 1 only.
- Assert reset after 2 of 5 words have been loaded.
  - Expect state IDLE and all reset values.
  - A full reload then proceeds normally.
